// File: rtl/instr_encoder_pkg.sv
// Shared opcode/funct3 constants and the field bundle for the instruction encoder.
package instr_encoder_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [2:0] FUNCT3_SYSTEM_CSRRW  = 3'b001;
  localparam logic [2:0] FUNCT3_SYSTEM_CSRRS  = 3'b010;
  localparam logic [2:0] FUNCT3_SYSTEM_CSRRC  = 3'b011;
  localparam logic [2:0] FUNCT3_SYSTEM_CSRRWI = 3'b101;
  localparam logic [2:0] FUNCT3_SYSTEM_CSRRSI = 3'b110;
  localparam logic [2:0] FUNCT3_SYSTEM_CSRRCI = 3'b111;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [11:0]     csr;
  } enc_fields_t;

  // CSR variants whose rs1 field carries a 5-bit zero-extended immediate
  function automatic logic is_csr_imm(input logic [2:0] funct3);
    return (funct3 == FUNCT3_SYSTEM_CSRRWI) || (funct3 == FUNCT3_SYSTEM_CSRRSI) ||
           (funct3 == FUNCT3_SYSTEM_CSRRCI);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_range_check.sv
// Decides whether an immediate is representable (range and alignment) for the given opcode.
module imm_range_check
  import instr_encoder_pkg::*;
(
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            legal_c
);

  // Sign-extension checks: upper bits must all equal the field's sign bit
  always_comb begin
    legal_c = 1'b0;
    case (opcode_i)
      OPCODE_LUI, OPCODE_AUIPC:
        legal_c = (imm_i[11:0] == 12'h000);
      OPCODE_JAL:
        legal_c = (imm_i[31:20] == {12{imm_i[20]}}) && !imm_i[0];
      OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_STORE:
        legal_c = (imm_i[31:11] == {21{imm_i[11]}});
      OPCODE_BRANCH:
        legal_c = (imm_i[31:12] == {20{imm_i[12]}}) && !imm_i[0];
      OPCODE_OP:
        legal_c = 1'b1;
      OPCODE_SYSTEM:
        legal_c = is_csr_imm(funct3_i) ? (imm_i[31:5] == 27'h0) : 1'b1;
      default:
        legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into an RV32I word through a two-stage valid/ready pipe.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [6:0]       opcode_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [11:0]      csr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  instr_o,
  output logic             err_o,
  output logic [CNT_W-1:0] enc_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            s1_valid;
  enc_fields_t     s1_f;
  logic            s1_legal_c;
  logic            s2_adv_c;
  logic [4:0]      sys_rs1_c;
  logic [XLEN-1:0] word_c;

  assign s2_adv_c   = !out_valid_o || out_ready_i;
  assign in_ready_o = !s1_valid || s2_adv_c;

  // S1: capture the fields whenever the stage is free or draining
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
    end else if (in_ready_o) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_f <= '{opcode: opcode_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i, funct3: funct3_i,
                  funct7: funct7_i, imm: imm_i, csr: csr_i};
      end
    end
  end

  imm_range_check u_imm_range_check (
    .opcode_i (s1_f.opcode),
    .funct3_i (s1_f.funct3),
    .imm_i    (s1_f.imm),
    .legal_c  (s1_legal_c)
  );

  assign sys_rs1_c = is_csr_imm(s1_f.funct3) ? s1_f.imm[4:0] : s1_f.rs1;

  // Format-specific bit placement of the S1 fields
  always_comb begin
    word_c = INSTR_NOP;
    case (s1_f.opcode)
      OPCODE_LUI, OPCODE_AUIPC:
        word_c = {s1_f.imm[31:12], s1_f.rd, s1_f.opcode};
      OPCODE_JAL:
        word_c = {s1_f.imm[20], s1_f.imm[10:1], s1_f.imm[11], s1_f.imm[19:12], s1_f.rd,
                  s1_f.opcode};
      OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM:
        word_c = {s1_f.imm[11:0], s1_f.rs1, s1_f.funct3, s1_f.rd, s1_f.opcode};
      OPCODE_STORE:
        word_c = {s1_f.imm[11:5], s1_f.rs2, s1_f.rs1, s1_f.funct3, s1_f.imm[4:0], s1_f.opcode};
      OPCODE_BRANCH:
        word_c = {s1_f.imm[12], s1_f.imm[10:5], s1_f.rs2, s1_f.rs1, s1_f.funct3,
                  s1_f.imm[4:1], s1_f.imm[11], s1_f.opcode};
      OPCODE_OP:
        word_c = {s1_f.funct7, s1_f.rs2, s1_f.rs1, s1_f.funct3, s1_f.rd, s1_f.opcode};
      OPCODE_SYSTEM:
        word_c = {s1_f.csr, sys_rs1_c, s1_f.funct3, s1_f.rd, s1_f.opcode};
      default:
        word_c = INSTR_NOP;
    endcase
  end

  // S2: output register, held while the consumer stalls; illegal entries become NOPs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      instr_o     <= INSTR_NOP;
      err_o       <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        instr_o <= s1_legal_c ? word_c : INSTR_NOP;
        err_o   <= !s1_legal_c;
      end
    end
  end

  // Saturating delivery counters, stepped on output handshakes only
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enc_cnt_o <= '0;
      err_cnt_o <= '0;
    end else if (out_valid_o && out_ready_i) begin
      if (enc_cnt_o != CNT_MAX) enc_cnt_o <= enc_cnt_o + CNT_W'(1);
      if (err_o && (err_cnt_o != CNT_MAX)) err_cnt_o <= err_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors, backpressure, async reset, random traffic.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int unsigned TB_CNT_W = 5;
  localparam int unsigned CNT_SAT  = 31;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [6:0]          opcode;
  logic [4:0]          rd, rs1, rs2;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [31:0]         imm;
  logic [11:0]         csr;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         instr;
  logic                err;
  logic [TB_CNT_W-1:0] enc_cnt;
  logic [TB_CNT_W-1:0] err_cnt;

  instr_encoder #(.CNT_W(TB_CNT_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .opcode_i    (opcode),
    .rd_i        (rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
    .imm_i       (imm),
    .csr_i       (csr),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .instr_o     (instr),
    .err_o       (err),
    .enc_cnt_o   (enc_cnt),
    .err_cnt_o   (err_cnt)
  );

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy_pct = 100;
  int   m_enc   = 0;
  int   m_err   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the ISA field layout using plain arithmetic
  function automatic exp_t ref_model(input enc_fields_t f);
    exp_t   e;
    longint s;
    logic [31:0] u, w, op, rdf, f3f, rs1f, rs2f, csrf;
    bit ok;
    u    = f.imm;
    s    = longint'($signed(f.imm));
    op   = 32'(f.opcode);
    rdf  = 32'(f.rd) * 128;
    f3f  = 32'(f.funct3) * 4096;
    rs1f = 32'(f.rs1) * 32768;
    rs2f = 32'(f.rs2) * 1048576;
    csrf = 32'(f.csr) * 1048576;
    ok   = 1'b1;
    w    = INSTR_NOP;
    case (f.opcode)
      OPCODE_LUI, OPCODE_AUIPC: begin
        ok = (u % 4096) == 0;
        w  = (u / 4096) * 4096 + rdf + op;
      end
      OPCODE_JAL: begin
        ok = (s >= -1048576) && (s <= 1048574) && (u % 2 == 0);
        w  = (((u >> 20) % 2) << 31) + (((u >> 1) % 1024) << 21) + (((u >> 11) % 2) << 20) +
             (((u >> 12) % 256) << 12) + rdf + op;
      end
      OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((u % 4096) << 20) + rs1f + f3f + rdf + op;
      end
      OPCODE_STORE: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((u >> 5) % 128) << 25) + rs2f + rs1f + f3f + ((u % 32) << 7) + op;
      end
      OPCODE_BRANCH: begin
        ok = (s >= -4096) && (s <= 4094) && (u % 2 == 0);
        w  = (((u >> 12) % 2) << 31) + (((u >> 5) % 64) << 25) + rs2f + rs1f + f3f +
             (((u >> 1) % 16) << 8) + (((u >> 11) % 2) << 7) + op;
      end
      OPCODE_OP:
        w = (32'(f.funct7) << 25) + rs2f + rs1f + f3f + rdf + op;
      OPCODE_SYSTEM: begin
        if (f.funct3 == 3'd5 || f.funct3 == 3'd6 || f.funct3 == 3'd7) begin
          ok = (s >= 0) && (s <= 31);
          w  = csrf + ((u % 32) << 15) + f3f + rdf + op;
        end else begin
          w = csrf + rs1f + f3f + rdf + op;
        end
      end
      default: ok = 1'b0;
    endcase
    e.instr = ok ? w : INSTR_NOP;
    e.err   = !ok;
    return e;
  endfunction

  function automatic enc_fields_t mk(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] im, input logic [11:0] c);
    enc_fields_t f;
    f = '{opcode: o, rd: d, rs1: s1, rs2: s2, funct3: f3, funct7: f7, imm: im, csr: c};
    return f;
  endfunction

  function automatic enc_fields_t rand_fields();
    logic [6:0]  ops[10];
    logic [31:0] edges[12];
    enc_fields_t f;
    ops   = '{OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_LOAD,
              OPCODE_OP_IMM, OPCODE_STORE, OPCODE_BRANCH, OPCODE_OP, OPCODE_SYSTEM};
    edges = '{32'hFFFFF800, 32'h000007FF, 32'h00000800, 32'hFFFFF7FF, 32'hFFFFF000,
              32'h00000FFE, 32'h00000FFF, 32'h00001000, 32'hFFF00000, 32'h000FFFFE,
              32'h000FFFFF, 32'h00000020};
    f.opcode = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
    f.rd     = 5'($urandom);
    f.rs1    = 5'($urandom);
    f.rs2    = 5'($urandom);
    f.funct3 = 3'($urandom);
    f.funct7 = 7'($urandom);
    f.csr    = 12'($urandom);
    case ($urandom_range(0, 5))
      0:       f.imm = $urandom;
      1:       f.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       f.imm = edges[$urandom_range(0, 11)];
      3:       f.imm = $urandom & 32'hFFFFF000;
      4:       f.imm = 32'($urandom_range(0, 40));
      default: f.imm = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
    endcase
    return f;
  endfunction

  // Offer one transaction; expectation enters the scoreboard at the accepting cycle
  task automatic send(input enc_fields_t f, input exp_t e);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    opcode = f.opcode; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
    funct3 = f.funct3; funct7 = f.funct7; imm = f.imm; csr = f.csr;
    for (int c = 0; c < 300 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never rose, expected an accept within 300 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input enc_fields_t f, input logic [31:0] ei, input logic ee);
    exp_t e;
    e.instr = ei;
    e.err   = ee;
    send(f, e);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (q.size() != 0 && c < 500) begin
      @(posedge clk);
      c++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries still pending, expected 0", q.size());
    end
  endtask

  // Consumer: random readiness, updated just after each rising edge
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor: compares outputs against the scoreboard head and models the counters
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_enc = 0;
        m_err = 0;
      end else begin
        check("enc_cnt", 32'(enc_cnt), 32'(m_enc));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        if (out_valid) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got instr 0x%08h with empty scoreboard", instr);
          end else begin
            h = q[0];
            check("instr", instr, h.instr);
            check("err", 32'(err), 32'(h.err));
            if (out_ready) begin
              void'(q.pop_front());
              if (m_enc < CNT_SAT) m_enc++;
              if (h.err && m_err < CNT_SAT) m_err++;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] held;
    int          tp;
    enc_fields_t f;
    rst_n = 1'b0; in_valid = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0; csr = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, INSTR_NOP);
    check("rst_err", 32'(err), 32'd0);
    check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed words; LUI also checks two-cycle latency
    send_exp(mk(OPCODE_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 12'd0), 32'h123452B7, 1'b0);
    @(negedge clk);
    check("latency_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_c2_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    send_exp(mk(OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 12'd0), 32'hFFF00093, 1'b0);
    send_exp(mk(OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 12'd0), 32'h001000EF, 1'b0);
    send_exp(mk(OPCODE_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 12'd0), 32'h0020A423, 1'b0);
    send_exp(mk(OPCODE_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2048, 12'd0), INSTR_NOP, 1'b1);
    send_exp(mk(OPCODE_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 12'd0), INSTR_NOP, 1'b1);
    send_exp(mk(7'h7F, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 12'd0), INSTR_NOP, 1'b1);
    send_exp(mk(OPCODE_SYSTEM, 5'd3, 5'd9, 5'd0, 3'd5, 7'd0, 32'd31, 12'h300), 32'h300FD1F3, 1'b0);
    send_exp(mk(OPCODE_SYSTEM, 5'd3, 5'd9, 5'd0, 3'd5, 7'd0, 32'd32, 12'h300), INSTR_NOP, 1'b1);
    send_exp(mk(OPCODE_SYSTEM, 5'd3, 5'd7, 5'd0, 3'd1, 7'd0, 32'd999, 12'h305), 32'h305391F3, 1'b0);
    send_exp(mk(OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 12'd0), 32'h800000EF, 1'b0);
    send_exp(mk(OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 12'd0), INSTR_NOP, 1'b1);
    drain();

    // Backpressure: consumer stalled, third offer must be refused
    @(negedge clk);
    rdy_pct = 0;
    @(posedge clk);
    #1;
    send(mk(OPCODE_OP, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0, 12'd0),
         ref_model(mk(OPCODE_OP, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0, 12'd0)));
    send(mk(OPCODE_LOAD, 5'd7, 5'd8, 5'd0, 3'd2, 7'd0, 32'hFFFFF800, 12'd0),
         ref_model(mk(OPCODE_LOAD, 5'd7, 5'd8, 5'd0, 3'd2, 7'd0, 32'hFFFFF800, 12'd0)));
    f = mk(OPCODE_AUIPC, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 12'd0);
    in_valid = 1'b1;
    opcode = f.opcode; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
    funct3 = f.funct3; funct7 = f.funct7; imm = f.imm; csr = f.csr;
    @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    held = instr;
    repeat (3) @(negedge clk);
    check("stall_in_ready_hold", 32'(in_ready), 32'd0);
    check("stall_instr_stable", instr, held);
    rdy_pct = 100;
    @(posedge clk);
    #1;
    tp = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("release_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) q.push_back(ref_model(f));
      end
      if (out_valid && out_ready) tp++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    check("release_throughput", 32'(tp), 32'd3);
    drain();

    // Random traffic with random backpressure; counters saturate along the way
    rdy_pct = 70;
    for (int n = 0; n < 250; n++) begin
      f = rand_fields();
      send(f, ref_model(f));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_pct = 100;
    drain();
    @(negedge clk);
    check("sat_enc_cnt", 32'(enc_cnt), CNT_SAT);

    // Asynchronous reset with both stages full
    @(negedge clk);
    rdy_pct = 0;
    @(posedge clk);
    #1;
    send(mk(OPCODE_OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5, 12'd0),
         ref_model(mk(OPCODE_OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5, 12'd0)));
    send(mk(OPCODE_LUI, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 12'd0),
         ref_model(mk(OPCODE_LUI, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 12'd0)));
    check("prerst_out_valid", 32'(out_valid), 32'd1);
    check("prerst_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_instr", instr, INSTR_NOP);
    check("arst_enc_cnt", 32'(enc_cnt), 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    rdy_pct = 100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("postrst_no_output", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send_exp(mk(OPCODE_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 12'd0), 32'h123452B7, 1'b0);
    drain();
    @(negedge clk);
    check("postrst_enc_cnt", 32'(enc_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
